// File: rtl/partition_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : partition_mac_if
// Purpose  : Control, sample-stream, weight-load and result signals of the
//            partition multiply-accumulate stage.
// Revision : 1.0 - initial release
// ============================================================================
interface partition_mac_if #(
  parameter int PARTITION_WIDTH  = 3,
  parameter int PARTITION_HEIGHT = 3,
  parameter int DATA_WIDTH       = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACC_WIDTH        = 24
);
  localparam int c_N  = PARTITION_WIDTH * PARTITION_HEIGHT;
  localparam int c_AW = (c_N > 1) ? $clog2(c_N) : 1;

  logic                    start;
  logic                    relu_en;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    weight_we;
  logic [c_AW-1:0]         weight_addr;
  logic [WEIGHT_WIDTH-1:0] weight_data;
  logic                    busy;
  logic [ACC_WIDTH-1:0]    result_out;
  logic                    result_valid;

  modport master (
    output start, relu_en, data_in, weight_we, weight_addr, weight_data,
    input  busy, result_out, result_valid
  );

  modport slave (
    input  start, relu_en, data_in, weight_we, weight_addr, weight_data,
    output busy, result_out, result_valid
  );
endinterface
`default_nettype wire

// File: rtl/partition_mac.sv
`default_nettype none
// ============================================================================
// Module   : partition_mac
// Purpose  : Multiplies one row-major window of memory samples by an internal
//            weight file and emits a signed, optionally ReLU-clipped sum.
// Revision : 1.0 - initial release
// ============================================================================
module partition_mac #(
  parameter int PARTITION_WIDTH  = 3,
  parameter int PARTITION_HEIGHT = 3,
  parameter int DATA_WIDTH       = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACC_WIDTH        = 24,
  parameter int READ_LATENCY     = 1
) (
  input  logic           clk,
  input  logic           rst,
  partition_mac_if.slave bus
);
  localparam int              c_N        = PARTITION_WIDTH * PARTITION_HEIGHT;
  localparam int              c_AW       = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int              c_PW       = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic [c_AW-1:0] c_LAST     = c_AW'(c_N - 1);
  localparam logic [c_AW:0]   c_N_EXT    = (c_AW + 1)'(c_N);
  localparam logic [1:0]      c_LAT_INIT = 2'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("partition_mac: READ_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  state_t                         r_state;
  logic [1:0]                     r_lat_cnt;
  logic [c_AW-1:0]                r_idx;
  logic signed [DATA_WIDTH-1:0]   r_sample;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic                           r_relu;
  logic                           r_busy;
  logic signed [ACC_WIDTH-1:0]    r_result;
  logic                           r_valid;
  logic signed [WEIGHT_WIDTH-1:0] r_weights [c_N];

  logic signed [c_PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic                           w_wr_ok;

  // Each sample is registered first and multiplied on the following edge,
  // which is why the result lands one edge after the last sample.
  assign w_prod  = r_sample * r_weights[r_idx];
  assign w_sum   = r_acc + {{(ACC_WIDTH - c_PW){w_prod[c_PW-1]}}, w_prod};
  assign w_wr_ok = bus.weight_we && !r_busy && ({1'b0, bus.weight_addr} < c_N_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_idx     <= '0;
      r_sample  <= '0;
      r_acc     <= '0;
      r_relu    <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      for (int i = 0; i < c_N; i++) begin
        r_weights[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (w_wr_ok) begin
        r_weights[bus.weight_addr] <= bus.weight_data;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_WAIT;
            r_busy    <= 1'b1;
            r_acc     <= '0;
            r_relu    <= bus.relu_en;
            r_lat_cnt <= c_LAT_INIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == 2'd0) begin
            r_sample <= bus.data_in;
            r_idx    <= '0;
            r_state  <= S_ACCUM;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        S_ACCUM: begin
          r_acc <= w_sum;
          if (r_idx == c_LAST) begin
            r_result <= (r_relu && w_sum[ACC_WIDTH-1]) ? '0 : w_sum;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_sample <= bus.data_in;
            r_idx    <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.result_out   = r_result;
  assign bus.result_valid = r_valid;
endmodule
`default_nettype wire

// File: doc/partition_mac.md
# partition_mac

Multiply-accumulate stage directly downstream of the partition read-address generator. It consumes the row-major stream of pixels that the feature-map memory returns for one PARTITION_WIDTH x PARTITION_HEIGHT window and multiplies each pixel by the matching kernel coefficient held in an internal weight file. It then emits one signed, optionally ReLU-clipped accumulation per window. The controller pulses `start` in the same cycle it raises `run` on the address generator.

## Interface
- PARTITION_WIDTH, 3: window columns.
- PARTITION_HEIGHT, 3: window rows; N = PARTITION_WIDTH*PARTITION_HEIGHT.
- DATA_WIDTH, 8: signed pixel width.
- WEIGHT_WIDTH, 8: signed coefficient width.
- ACC_WIDTH, 24: signed accumulator/result width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(N).
- READ_LATENCY, 1: cycles from the address generator's first `run` edge to the first valid memory data; legal range 1..4.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin one window; ignored while busy.
- relu_en  in  1  sampled with start; 1 = clamp negative results to 0.
- data_in  in  DATA_WIDTH  signed memory read data.
- weight_we  in  1  weight-file write strobe.
- weight_addr  in  clog2(N)  weight index, row-major; indices >= N are ignored.
- weight_data  in  WEIGHT_WIDTH  signed coefficient.
- busy  out  1  window in progress.
- result_out  out  ACC_WIDTH  signed window result; held until the next result.
- result_valid  out  1  one-cycle pulse when result_out updates.

## Operation
- States:
  - IDLE: waits for start.
  - WAIT: burns READ_LATENCY memory cycles.
  - ACCUM: consumes N samples.
  - Transitions: IDLE -> WAIT on start; WAIT -> ACCUM after the latency count; ACCUM -> IDLE after sample N-1.
- The start edge clears the accumulator to 0, latches relu_en and sets busy.
- Element k (k = 0..N-1, row-major, k = row*PARTITION_WIDTH + col) is sampled from data_in and multiplied by weight[k].
- Products are full width (DATA_WIDTH+WEIGHT_WIDTH), sign-extended to ACC_WIDTH and added. Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
- Final result = latched relu_en && acc < 0 ? 0 : acc, including the last product.
- Weight file: N x WEIGHT_WIDTH registers, reset to 0.
  - A write takes effect at the edge where weight_we=1 and busy=0.
  - Writes while busy=1 are dropped, so the running window never sees a coefficient change.
- start while busy=1 is ignored; the window in progress is unaffected.
- data_in is don't-care outside sample edges.

## Timing
- Reset values: busy=0, result_out=0, result_valid=0, state IDLE, accumulator 0, all weights 0.
- Reset mid-window aborts it: no result_valid is produced, and the next start after reset release runs normally.
- Let t0 be the edge where start=1 and busy=0 are sampled. Then:
  - busy=1 from t0.
  - Element k is sampled at edge t0+READ_LATENCY+k.
  - The last element is sampled at t0+READ_LATENCY+N-1.
  - result_out and result_valid=1 are registered at edge t0+READ_LATENCY+N.
  - busy=0 from that same edge.
- Latency from start to result_valid is READ_LATENCY+N cycles.
- Back-to-back windows: start may be high in the cycle result_valid is high. It is accepted at the following edge because busy=0, giving a new window every READ_LATENCY+N+1 cycles.
- result_valid deasserts at the edge after it rises, unconditionally.
- A weight write at the same edge as t0 is accepted, since busy=0 is sampled there, and is visible to the window.

## Test plan
- 3x3, READ_LATENCY=1, weights 1..9, data_in=1 for all 9 samples -> result_valid at t0+10, result_out=45, busy high for exactly t0..t0+9.
- Same weights, data_in=-1, relu_en=1 -> result_out=0; repeat with relu_en=0 -> result_out=-45 (0xFFFFD3).
- READ_LATENCY=3, weights all 2, data_in = 0..8 in order (garbage on data_in during the three wait cycles) -> result_out=72 at t0+12; the garbage does not contribute.
- Back-to-back: start held high continuously for two windows of all-1 data with all-1 weights -> two result_valid pulses of 9, 11 cycles apart (READ_LATENCY=1); the second start, pulsed mid-first-window, is ignored.
- Write weight[0]=100 during busy, then run data=1 with all other weights 0 -> result_out equals the pre-write weight[0], proving the write was dropped.
- Assert rst at t0+5 of a window -> busy=0, result_out=0, no result_valid, weights cleared to 0; a fresh window after reset returns 0 for any data.
